// File: rtl/l1_host_adapter_if.sv
// rtl/l1_host_adapter_if.sv - core data port and interconnect host port bundle
interface l1_host_adapter_if #(
  parameter int DataWidth = 32
);
  logic                   data_req_i;
  logic                   data_gnt_o;
  logic                   data_we_i;
  logic [DataWidth/8-1:0] data_be_i;
  logic [DataWidth-1:0]   data_addr_i;
  logic [DataWidth-1:0]   data_wdata_i;
  logic                   data_rvalid_o;
  logic                   data_err_o;
  logic [DataWidth-1:0]   data_rdata_o;
  logic                   net_req_valid_o;
  logic                   net_req_ready_i;
  logic                   net_gnt_i;
  logic [DataWidth-1:0]   net_tgt_addr_o;
  logic                   net_we_o;
  logic [DataWidth/8-1:0] net_be_o;
  logic [DataWidth-1:0]   net_wdata_o;
  logic                   net_resp_valid_i;
  logic                   net_resp_ready_o;
  logic [DataWidth-1:0]   net_resp_data_i;

  // Environment side: drives the core request and the interconnect answers.
  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output net_req_ready_i, net_gnt_i, net_resp_valid_i, net_resp_data_i,
    input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    input  net_req_valid_o, net_tgt_addr_o, net_we_o, net_be_o, net_wdata_o,
    input  net_resp_ready_o
  );

  // Adapter side.
  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  net_req_ready_i, net_gnt_i, net_resp_valid_i, net_resp_data_i,
    output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    output net_req_valid_o, net_tgt_addr_o, net_we_o, net_be_o, net_wdata_o,
    output net_resp_ready_o
  );
endinterface

// File: rtl/l1_host_adapter.sv
// rtl/l1_host_adapter.sv - Ibex data port to L1 interconnect host 0 bridge
module l1_host_adapter #(
  parameter int                   DataWidth     = 32,
  parameter int                   TimeoutCycles = 64,
  parameter logic [DataWidth-1:0] ErrData       = 32'hBADCAB1E
) (
  input  logic             clk_sys_in,
  input  logic             rst_sys_in,
  l1_host_adapter_if.slave bus,
  output logic [7:0]       err_count_o
);

  localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  localparam logic [DataWidth-1:0] RamBase   = DataWidth'(32'h0020_0000);
  localparam logic [DataWidth-1:0] RamSize   = DataWidth'(32'h0001_0000);
  localparam logic [DataWidth-1:0] GpioBase  = DataWidth'(32'h8000_0000);
  localparam logic [DataWidth-1:0] UartBase  = DataWidth'(32'h8000_1000);
  localparam logic [DataWidth-1:0] TimerBase = DataWidth'(32'h8000_2000);
  localparam logic [DataWidth-1:0] FrsBase   = DataWidth'(32'h7000_0000);
  localparam logic [DataWidth-1:0] PeriSize  = DataWidth'(32'h0000_1000);
  localparam logic [DataWidth-1:0] SimBase   = DataWidth'(32'h0002_0000);
  localparam logic [DataWidth-1:0] SimSize   = DataWidth'(32'h0000_0400);

  typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, ERR_RESP} state_t;

  state_t               state;
  logic [CntW-1:0]      to_cnt;
  logic [1:0]           stale_cnt;
  logic [1:0]           stale_dec;
  logic [1:0]           stale_nxt;
  logic                 rvalid_q;
  logic                 err_q;
  logic [DataWidth-1:0] rdata_q;
  logic [7:0]           err_cnt;
  logic                 mapped;
  logic [2:0]           dev_idx;
  logic                 is_idle;
  logic                 gnt;
  logic                 resp_stale;
  logic                 resp_take;
  logic                 timeout;

  // Half-open window test; subtracting first keeps base+size from overflowing.
  function automatic logic in_win(input logic [DataWidth-1:0] a,
                                  input logic [DataWidth-1:0] base,
                                  input logic [DataWidth-1:0] size);
    return (a >= base) && ((a - base) < size);
  endfunction

  // Address decode into interconnect device index.
  always_comb begin
    mapped  = 1'b1;
    dev_idx = 3'd0;
    if (in_win(bus.data_addr_i, RamBase, RamSize))         dev_idx = 3'd0;
    else if (in_win(bus.data_addr_i, GpioBase, PeriSize))  dev_idx = 3'd1;
    else if (in_win(bus.data_addr_i, UartBase, PeriSize))  dev_idx = 3'd2;
    else if (in_win(bus.data_addr_i, TimerBase, PeriSize)) dev_idx = 3'd3;
    else if (in_win(bus.data_addr_i, FrsBase, PeriSize))   dev_idx = 3'd4;
    else if (in_win(bus.data_addr_i, SimBase, SimSize))    dev_idx = 3'd5;
    else                                                   mapped  = 1'b0;
  end

  assign is_idle = (state == IDLE);
  assign gnt     = bus.data_req_i & is_idle & (~mapped | (bus.net_req_ready_i & bus.net_gnt_i));

  assign bus.data_gnt_o       = gnt;
  assign bus.net_req_valid_o  = bus.data_req_i & is_idle & mapped;
  assign bus.net_tgt_addr_o   = {bus.data_addr_i[DataWidth-6:0], dev_idx, 2'b00};
  assign bus.net_we_o         = bus.data_we_i;
  assign bus.net_be_o         = bus.data_be_i;
  assign bus.net_wdata_o      = bus.data_wdata_i;
  assign bus.net_resp_ready_o = 1'b1;
  assign bus.data_rvalid_o    = rvalid_q;
  assign bus.data_err_o       = err_q;
  assign bus.data_rdata_o     = rdata_q;
  assign err_count_o          = err_cnt;

  // Any response while stale responses are owed is absorbed, whatever the state.
  assign resp_stale = bus.net_resp_valid_i & (stale_cnt != 2'd0);
  assign resp_take  = bus.net_resp_valid_i & (stale_cnt == 2'd0) & (state == RD_WAIT);
  assign timeout    = (state == RD_WAIT) & (to_cnt == CntW'(TimeoutCycles - 1)) & ~resp_take;

  // A timed-out read leaves one late response in flight; remember to discard it.
  always_comb begin
    stale_dec = stale_cnt - {1'b0, resp_stale};
    stale_nxt = stale_dec;
    if (timeout && stale_dec != 2'd3) stale_nxt = stale_dec + 2'd1;
  end

  // Transaction FSM with registered completion outputs.
  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      state     <= IDLE;
      to_cnt    <= '0;
      stale_cnt <= 2'd0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      err_cnt   <= 8'd0;
    end else begin
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      stale_cnt <= stale_nxt;
      case (state)
        IDLE: begin
          if (gnt) begin
            if (!mapped) begin
              state    <= ERR_RESP;
              rvalid_q <= 1'b1;
              err_q    <= 1'b1;
              rdata_q  <= ErrData;
              if (err_cnt != 8'd255) err_cnt <= err_cnt + 8'd1;
            end else if (bus.data_we_i) begin
              state    <= WR_ACK;
              rvalid_q <= 1'b1;
              rdata_q  <= '0;
            end else begin
              state  <= RD_WAIT;
              to_cnt <= '0;
            end
          end
        end
        RD_WAIT: begin
          if (resp_take) begin
            state    <= IDLE;
            rvalid_q <= 1'b1;
            rdata_q  <= bus.net_resp_data_i;
          end else if (timeout) begin
            state    <= ERR_RESP;
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= ErrData;
            if (err_cnt != 8'd255) err_cnt <= err_cnt + 8'd1;
          end else begin
            to_cnt <= to_cnt + CntW'(1);
          end
        end
        WR_ACK:   state <= IDLE;
        ERR_RESP: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // A response with no read waiting and nothing stale owed is silently dropped.
  assert property (@(posedge clk_sys_in) disable iff (!rst_sys_in)
    !(bus.net_resp_valid_i && (state != RD_WAIT) && (stale_cnt == 2'd0)));

endmodule

// File: tb/tb_l1_host_adapter.sv
// tb/tb_l1_host_adapter.sv - randomized model-checked bench for l1_host_adapter
module tb_l1_host_adapter;
  localparam int DW = 32;
  localparam int TO = 64;
  localparam logic [31:0] ERRD = 32'hBADCAB1E;
  localparam logic [31:0] WIN_BASE [6] = '{32'h0020_0000, 32'h8000_0000, 32'h8000_1000,
                                           32'h8000_2000, 32'h7000_0000, 32'h0002_0000};
  localparam int unsigned WIN_SIZE [6] = '{65536, 4096, 4096, 4096, 4096, 1024};

  logic       clk_sys_in = 1'b0;
  logic       rst_sys_in = 1'b0;
  logic [7:0] err_count_o;

  l1_host_adapter_if #(.DataWidth(DW)) bus ();

  l1_host_adapter #(.DataWidth(DW), .TimeoutCycles(TO), .ErrData(ERRD)) dut (
    .clk_sys_in (clk_sys_in),
    .rst_sys_in (rst_sys_in),
    .bus        (bus),
    .err_count_o(err_count_o)
  );

  always #5 clk_sys_in = ~clk_sys_in;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  logic        e_gnt, e_req_valid, e_we, e_rvalid, e_err;
  logic [3:0]  e_be;
  logic [31:0] e_tgt, e_wdata, e_rdata;
  logic [7:0]  e_errcnt;

  int          stale_m;
  logic [31:0] m_rdata;
  int          m_errcnt;
  logic [32:0] cpl [int];

  int          last_gnt_cyc, last_cpl_cyc;
  logic [31:0] last_cpl_data, last_tgt;
  logic        last_cpl_err;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
  endfunction

  function automatic int dev_of(input logic [31:0] a);
    for (int i = 0; i < 6; i++)
      if (longint'(a) >= longint'(WIN_BASE[i]) && longint'(a) < longint'(WIN_BASE[i]) + longint'(WIN_SIZE[i]))
        return i;
    return -1;
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] a, input int dev);
    return ((a & 32'h07FF_FFFF) << 5) | (32'(dev) << 2);
  endfunction

  function automatic void sched(input int c, input logic e, input logic [31:0] d);
    cpl[c] = {e, d};
  endfunction

  function automatic logic [31:0] rand_addr();
    int i = $urandom_range(0, 5);
    case ($urandom_range(0, 9))
      0: return WIN_BASE[i];
      1: return WIN_BASE[i] + WIN_SIZE[i] - 1;
      2: return WIN_BASE[i] + WIN_SIZE[i];
      3: return WIN_BASE[i] - 1;
      4: return 32'h0010_0000 + 32'($urandom_range(0, 255));
      5: return $urandom;
      default: return WIN_BASE[i] + 32'($urandom_range(0, WIN_SIZE[i] - 1));
    endcase
  endfunction

  // Compare DUT outputs against the model every cycle, mid-cycle.
  always @(negedge clk_sys_in) begin
    if (chk_en) begin
      chk("data_gnt", 32'(bus.data_gnt_o), 32'(e_gnt));
      chk("net_req_valid", 32'(bus.net_req_valid_o), 32'(e_req_valid));
      if (e_req_valid) begin
        chk("net_tgt_addr", bus.net_tgt_addr_o, e_tgt);
        chk("net_we", 32'(bus.net_we_o), 32'(e_we));
        chk("net_be", 32'(bus.net_be_o), 32'(e_be));
        chk("net_wdata", bus.net_wdata_o, e_wdata);
      end
      chk("net_resp_ready", 32'(bus.net_resp_ready_o), 32'd1);
      chk("data_rvalid", 32'(bus.data_rvalid_o), 32'(e_rvalid));
      chk("data_err", 32'(bus.data_err_o), 32'(e_err));
      chk("data_rdata", bus.data_rdata_o, e_rdata);
      chk("err_count", 32'(err_count_o), 32'(e_errcnt));
      if (bus.data_gnt_o) last_gnt_cyc = cyc;
      if (bus.data_gnt_o && bus.net_req_valid_o) last_tgt = bus.net_tgt_addr_o;
      if (bus.data_rvalid_o) begin
        last_cpl_cyc  = cyc;
        last_cpl_data = bus.data_rdata_o;
        last_cpl_err  = bus.data_err_o;
      end
    end
  end

  task automatic step();
    @(posedge clk_sys_in);
    #1;
    cyc++;
    if (cpl.exists(cyc)) begin
      e_rvalid = 1'b1;
      e_err    = cpl[cyc][32];
      m_rdata  = cpl[cyc][31:0];
      if (e_err && m_errcnt < 255) m_errcnt++;
      cpl.delete(cyc);
    end else begin
      e_rvalid = 1'b0;
      e_err    = 1'b0;
    end
    e_rdata  = m_rdata;
    e_errcnt = 8'(m_errcnt);
    bus.data_req_i       = 1'b0;
    bus.data_we_i        = 1'($urandom_range(0, 1));
    bus.data_be_i        = 4'($urandom_range(0, 15));
    bus.data_addr_i      = $urandom;
    bus.data_wdata_i     = $urandom;
    bus.net_gnt_i        = 1'($urandom_range(0, 1));
    bus.net_req_ready_i  = 1'($urandom_range(0, 1));
    bus.net_resp_valid_i = 1'b0;
    bus.net_resp_data_i  = $urandom;
    e_gnt       = 1'b0;
    e_req_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk_sys_in);
    #1;
  endtask

  task automatic do_reset();
    rst_sys_in = 1'b0;
    #1;
    chk("async_rst_rvalid", 32'(bus.data_rvalid_o), 32'd0);
    chk("async_rst_err", 32'(bus.data_err_o), 32'd0);
    chk("async_rst_rdata", bus.data_rdata_o, 32'd0);
    chk("async_rst_errcnt", 32'(err_count_o), 32'd0);
    stale_m  = 0;
    m_rdata  = 32'd0;
    m_errcnt = 0;
    cpl.delete();
    bus.data_req_i       = 1'b0;
    bus.net_resp_valid_i = 1'b0;
    e_gnt = 1'b0; e_req_valid = 1'b0; e_rvalid = 1'b0; e_err = 1'b0;
    e_rdata = 32'd0; e_errcnt = 8'd0;
    step();
    step();
    rst_sys_in = 1'b1;
  endtask

  task automatic txn(input logic [31:0] a, input logic we, input int gnt_hold, input int rand_w,
                     input int lat, input bit to_mode, input bit stale_rand,
                     input logic [31:0] rd_data, input logic [31:0] stale_data,
                     input int rst_k, output int start_cyc);
    int          dev;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        rv;
    dev = dev_of(a);
    be  = 4'($urandom_range(0, 15));
    wd  = $urandom;
    start_cyc = -1;
    for (int waited = 0; waited <= gnt_hold + rand_w; waited++) begin
      step();
      if (start_cyc < 0) start_cyc = cyc;
      bus.data_req_i   = 1'b1;
      bus.data_addr_i  = a;
      bus.data_we_i    = we;
      bus.data_be_i    = be;
      bus.data_wdata_i = wd;
      if (waited < gnt_hold) bus.net_gnt_i = 1'b0;
      else if (waited == gnt_hold + rand_w) begin
        bus.net_gnt_i       = 1'b1;
        bus.net_req_ready_i = 1'b1;
      end
      e_req_valid = (dev >= 0);
      e_tgt   = tgt_of(a, dev);
      e_we    = we;
      e_be    = be;
      e_wdata = wd;
      e_gnt   = (dev < 0) || (bus.net_gnt_i && bus.net_req_ready_i);
      if (e_gnt) break;
    end
    if (dev < 0) begin
      sched(cyc + 1, 1'b1, ERRD);
      step();
      return;
    end
    if (we) begin
      sched(cyc + 1, 1'b0, 32'd0);
      step();
      return;
    end
    for (int k = 0; k < TO; k++) begin
      step();
      if (k == rst_k) begin
        do_reset();
        return;
      end
      rv = (!to_mode && k >= lat) || (stale_rand && stale_m > 0 && $urandom_range(0, 3) == 0);
      bus.net_resp_valid_i = rv;
      bus.net_resp_data_i  = (stale_m > 0) ? (stale_rand ? $urandom : stale_data) : rd_data;
      if (rv && stale_m > 0) stale_m--;
      else if (rv) begin
        sched(cyc + 1, 1'b0, rd_data);
        step();
        return;
      end
      if (k == TO - 1) begin
        if (stale_m < 3) stale_m++;
        sched(cyc + 1, 1'b1, ERRD);
        step();
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sc;
    int c0;
    logic [31:0] a;
    stale_m = 0; m_rdata = 32'd0; m_errcnt = 0;
    e_gnt = 0; e_req_valid = 0; e_we = 0; e_be = 0; e_tgt = 0; e_wdata = 0;
    e_rvalid = 0; e_err = 0; e_rdata = 0; e_errcnt = 0;
    last_gnt_cyc = 0; last_cpl_cyc = 0; last_cpl_data = 0; last_tgt = 0; last_cpl_err = 0;
    bus.data_req_i = 0; bus.data_we_i = 0; bus.data_be_i = 0; bus.data_addr_i = 0;
    bus.data_wdata_i = 0; bus.net_req_ready_i = 0; bus.net_gnt_i = 0;
    bus.net_resp_valid_i = 0; bus.net_resp_data_i = 0;

    repeat (2) step();
    chk_en = 1'b1;
    step();
    chk("reset_rvalid", 32'(bus.data_rvalid_o), 32'd0);
    chk("reset_rdata", bus.data_rdata_o, 32'd0);
    chk("reset_errcnt", 32'(err_count_o), 32'd0);
    rst_sys_in = 1'b1;

    txn(32'h0020_0010, 1'b0, 0, 0, 2, 1'b0, 1'b0, 32'h1234_5678, 32'd0, -1, sc);
    settle();
    chk("lit_ram_tgt", last_tgt, 32'h0400_0200);
    chk("lit_ram_rdata", last_cpl_data, 32'h1234_5678);
    chk("lit_ram_latency", 32'(last_cpl_cyc - last_gnt_cyc), 32'd4);

    step();
    c0 = cyc;
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'b0011;
    bus.data_addr_i = 32'h8000_0004; bus.data_wdata_i = 32'hCAFE_0001;
    bus.net_gnt_i = 1'b1; bus.net_req_ready_i = 1'b1;
    e_gnt = 1'b1; e_req_valid = 1'b1; e_tgt = 32'h0000_0084;
    e_we = 1'b1; e_be = 4'b0011; e_wdata = 32'hCAFE_0001;
    sched(c0 + 1, 1'b0, 32'd0);
    step();
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'b0011;
    bus.data_addr_i = 32'h8000_0008; bus.data_wdata_i = 32'hCAFE_0002;
    bus.net_gnt_i = 1'b1; bus.net_req_ready_i = 1'b1;
    step();
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'b0011;
    bus.data_addr_i = 32'h8000_0008; bus.data_wdata_i = 32'hCAFE_0002;
    bus.net_gnt_i = 1'b1; bus.net_req_ready_i = 1'b1;
    e_gnt = 1'b1; e_req_valid = 1'b1; e_tgt = 32'h0000_0104; e_wdata = 32'hCAFE_0002;
    sched(cyc + 1, 1'b0, 32'd0);
    step();
    settle();
    chk("lit_b2b_gap", 32'(last_gnt_cyc - c0), 32'd2);

    txn(32'h0010_0000, 1'b0, 0, 0, 0, 1'b0, 1'b0, 32'd0, 32'd0, -1, sc);
    settle();
    chk("lit_unmapped_rdata", last_cpl_data, 32'hBADC_AB1E);
    chk("lit_unmapped_err", 32'(last_cpl_err), 32'd1);
    chk("lit_unmapped_errcnt", 32'(err_count_o), 32'd1);

    txn(32'h7000_0000, 1'b0, 5, 0, 1, 1'b0, 1'b0, 32'h0F0F_1234, 32'd0, -1, sc);
    settle();
    chk("lit_gnt_wait", 32'(last_gnt_cyc - sc), 32'd5);
    chk("lit_fraise_rdata", last_cpl_data, 32'h0F0F_1234);

    txn(32'h0020_0100, 1'b0, 0, 0, 0, 1'b1, 1'b0, 32'd0, 32'd0, -1, sc);
    settle();
    chk("lit_timeout_cycles", 32'(last_cpl_cyc - last_gnt_cyc), 32'd65);
    chk("lit_timeout_err", 32'(last_cpl_err), 32'd1);
    txn(32'h0020_0104, 1'b0, 0, 0, 1, 1'b0, 1'b0, 32'h0000_5555, 32'h0000_AAAA, -1, sc);
    settle();
    chk("lit_after_stale_rdata", last_cpl_data, 32'h0000_5555);
    chk("lit_after_stale_err", 32'(last_cpl_err), 32'd0);

    txn(32'h0020_0200, 1'b0, 0, 0, 10, 1'b0, 1'b0, 32'h1111_2222, 32'd0, 3, sc);
    txn(32'h0002_0010, 1'b0, 0, 0, 2, 1'b0, 1'b0, 32'h3333_4444, 32'd0, -1, sc);
    settle();
    chk("lit_post_reset_rdata", last_cpl_data, 32'h3333_4444);

    for (int n = 0; n < 200; n++) begin
      a = rand_addr();
      txn(a, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 4),
          $urandom_range(0, 5), ($urandom_range(0, 11) == 0), 1'b1, $urandom, 32'd0, -1, sc);
    end

    for (int n = 0; n < 260; n++)
      txn(32'h0010_0000 + 32'(4 * n), 1'($urandom_range(0, 1)), 0, 0, 0, 1'b0, 1'b0,
          32'd0, 32'd0, -1, sc);
    settle();
    chk("lit_errcnt_saturated", 32'(err_count_o), 32'd255);

    step();
    settle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
